// File: rtl/drum_pkg.sv
// drum_pkg: shared transport state type and tempo defaults for the step sequencer
package drum_pkg;
    typedef enum logic {IDLE, PLAY} state_t;
    localparam int DEFAULT_BPM        = 120;
    localparam int DEFAULT_TICK_LIMIT = 750000000;
endpackage

// File: rtl/tempo_accum.sv
// tempo_accum: bpm phase accumulator that decides when the sequencer advances a step
module tempo_accum import drum_pkg::*; #(
    parameter int BPM_W      = 8,
    parameter int TICK_LIMIT = DEFAULT_TICK_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             run,
    input  logic [BPM_W-1:0] bpm,
    output logic             adv,
    output logic             step_tick
);
    localparam int ACC_W = $clog2(TICK_LIMIT + (1 << BPM_W));
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(TICK_LIMIT);
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             tick_q, tick_d;
    always_comb begin
        sum    = acc_q + ACC_W'(bpm);
        adv    = run && !restart && sum >= LIMIT;
        // keep the remainder past the limit so the long-run tempo does not drift
        acc_d  = (restart || !run) ? '0 : adv ? sum - LIMIT : sum;
        tick_d = restart || adv;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end
    assign step_tick = tick_q;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: multi-channel drum step sequencer with pattern RAM and transport FSM
module step_sequencer import drum_pkg::*; #(
    parameter int NUM_CH     = 4,
    parameter int NUM_STEPS  = 8,
    parameter int BPM_W      = 8,
    parameter int TICK_LIMIT = DEFAULT_TICK_LIMIT,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SW        = $clog2(NUM_STEPS),
    localparam int LW        = SW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [NUM_STEPS-1:0] cfg_pattern,
    input  logic                 bpm_we,
    input  logic [BPM_W-1:0]     bpm_in,
    input  logic                 len_we,
    input  logic [LW-1:0]        len_in,
    input  logic [NUM_CH-1:0]    mute,
    input  logic                 start,
    input  logic                 stop,
    output logic [NUM_CH-1:0]    trig_out,
    output logic [SW-1:0]        step_idx,
    output logic                 step_tick,
    output logic                 playing
);
    state_t               state_q, state_d;
    logic [NUM_STEPS-1:0] pat_q [NUM_CH];
    logic [NUM_STEPS-1:0] pat_d [NUM_CH];
    logic [BPM_W-1:0]     bpm_q, bpm_d;
    logic [LW-1:0]        len_q, len_d, nxt;
    logic [SW-1:0]        step_q, step_d;
    logic [NUM_CH-1:0]    trig_q, trig_d;
    logic                 go, run, adv;
    always_comb begin
        go      = start && !stop;
        run     = state_q == PLAY && !stop;
        state_d = stop ? IDLE : go ? PLAY : state_q;
        pat_d   = pat_q;
        if (cfg_we && 32'(cfg_ch) < NUM_CH)
            pat_d[cfg_ch] = cfg_pattern;
        bpm_d   = bpm_we ? bpm_in : bpm_q;
        len_d   = (len_we && len_in != '0 && 32'(len_in) <= NUM_STEPS) ? len_in : len_q;
        nxt     = {1'b0, step_q} + LW'(1);
        // a shortened loop can leave step_q past the end; the >= compare sends it home
        step_d  = (go || state_d == IDLE) ? '0 : !adv ? step_q : (nxt >= len_q) ? '0 : nxt[SW-1:0];
        for (int c = 0; c < NUM_CH; c++)
            trig_d[c] = (go || adv) && pat_q[c][step_d] && !mute[c];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '{default: '0};
            bpm_q   <= BPM_W'(DEFAULT_BPM);
            len_q   <= LW'(NUM_STEPS);
            step_q  <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            bpm_q   <= bpm_d;
            len_q   <= len_d;
            step_q  <= step_d;
            trig_q  <= trig_d;
        end
    end
    tempo_accum #(.BPM_W(BPM_W), .TICK_LIMIT(TICK_LIMIT)) u_tempo (
        .clk       (clk),
        .reset     (reset),
        .restart   (go),
        .run       (run),
        .bpm       (bpm_q),
        .adv       (adv),
        .step_tick (step_tick)
    );
    assign trig_out = trig_q;
    assign step_idx = step_q;
    assign playing  = state_q == PLAY;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: vector table plus tempo/transport sequences, checked through a scoreboard queue
module tb_step_sequencer;
    logic       clk = 1'b0;
    logic       reset, cfg_we, bpm_we, len_we, start, stop;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_pattern, bpm_in;
    logic [3:0] len_in, mute, trig_out;
    logic [2:0] step_idx;
    logic       step_tick, playing;

    typedef struct {
        logic       rst, start, stop, cfg_we;
        logic [1:0] cfg_ch;
        logic [7:0] cfg_pat;
        logic       bpm_we;
        logic [7:0] bpm;
        logic       len_we;
        logic [3:0] len, mute;
        logic [3:0] trig;
        logic [2:0] idx;
        logic       tick, play;
    } vec_t;

    typedef struct {
        logic [3:0] trig;
        logic [2:0] idx;
        logic       tick, play;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[43];

    step_sequencer #(.NUM_CH(4), .NUM_STEPS(8), .BPM_W(8), .TICK_LIMIT(100)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
        .bpm_we(bpm_we), .bpm_in(bpm_in), .len_we(len_we), .len_in(len_in), .mute(mute),
        .start(start), .stop(stop), .trig_out(trig_out), .step_idx(step_idx),
        .step_tick(step_tick), .playing(playing)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rst, st, sp, cw, input logic [1:0] ch, input logic [7:0] pat,
                               input logic bw, input logic [7:0] b, input logic lw, input logic [3:0] l,
                               input logic [3:0] m, input logic [3:0] t, input logic [2:0] i,
                               input logic tk, pl);
        vec_t x;
        x = '{rst, st, sp, cw, ch, pat, bw, b, lw, l, m, t, i, tk, pl};
        return x;
    endfunction

    function automatic vec_t nop();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // inputs go in before the edge; the expectation is what the outputs must show after it
    task automatic apply(input vec_t x, input string nm);
        exp_t e;
        reset = x.rst; start = x.start; stop = x.stop;
        cfg_we = x.cfg_we; cfg_ch = x.cfg_ch; cfg_pattern = x.cfg_pat;
        bpm_we = x.bpm_we; bpm_in = x.bpm; len_we = x.len_we; len_in = x.len; mute = x.mute;
        sb.push_back('{trig: x.trig, idx: x.idx, tick: x.tick, play: x.play, name: nm});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (trig_out !== e.trig || step_idx !== e.idx || step_tick !== e.tick || playing !== e.play) begin
            n_bad++;
            $display("FAIL %s: got trig=%h idx=%0d tick=%b play=%b, want trig=%h idx=%0d tick=%b play=%b",
                     e.name, trig_out, step_idx, step_tick, playing, e.trig, e.idx, e.tick, e.play);
        end
    endtask

    initial begin
        vec_t x;
        int   tk_at[11];
        int   nt;
        //            rst st sp cw ch pat    bw b    lw l  m    trig idx tk pl
        tbl[0]  = v(1, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 1, 0, 8'h55, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 1, 1, 8'h01, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0, 8'h00, 1, 100, 0, 0, 0,   0, 0, 0, 0);
        tbl[4]  = v(0, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[5]  = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 1, 1, 1);
        tbl[6]  = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   1, 2, 1, 1);
        tbl[7]  = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 3, 1, 1);
        tbl[8]  = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1,   0, 4, 1, 1);
        tbl[9]  = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1,   0, 5, 1, 1);
        tbl[10] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 1,   0, 6, 1, 1);
        tbl[11] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 7, 1, 1);
        tbl[12] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[13] = v(0, 0, 0, 1, 1, 8'hFF, 0, 0,   0, 0, 0,   0, 1, 1, 1);
        tbl[14] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 2, 1, 1);
        tbl[15] = v(0, 0, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[16] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[17] = v(0, 1, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        tbl[18] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   1, 0, 0,   0, 0, 0, 0);
        tbl[19] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   1, 9, 0,   0, 0, 0, 0);
        tbl[20] = v(0, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[21] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 1, 1, 1);
        tbl[22] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 2, 1, 1);
        tbl[23] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 3, 1, 1);
        tbl[24] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 4, 1, 1);
        tbl[25] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 5, 1, 1);
        tbl[26] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 6, 1, 1);
        tbl[27] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 7, 1, 1);
        tbl[28] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[29] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 1, 1, 1);
        tbl[30] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 2, 1, 1);
        tbl[31] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 3, 1, 1);
        tbl[32] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 4, 1, 1);
        tbl[33] = v(0, 0, 0, 0, 0, 8'h00, 1, 0,   0, 0, 0,   2, 5, 1, 1);
        tbl[34] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   1, 3, 0,   0, 5, 0, 1);
        tbl[35] = v(0, 0, 0, 0, 0, 8'h00, 1, 100, 0, 0, 0,   0, 5, 0, 1);
        tbl[36] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[37] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 1, 1, 1);
        tbl[38] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 2, 1, 1);
        tbl[39] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[40] = v(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   2, 1, 1, 1);
        tbl[41] = v(0, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0,   3, 0, 1, 1);
        tbl[42] = v(0, 1, 1, 0, 0, 8'h00, 0, 0,   0, 0, 0,   0, 0, 0, 0);

        for (int i = 0; i < 43; i++)
            apply(tbl[i], $sformatf("vec[%0d]", i));

        // steady tempo: bpm 10 against a limit of 100 gives a tick every 10 cycles
        x = nop(); x.len_we = 1; x.len = 8; apply(x, "len8");
        for (int c = 0; c < 4; c++) begin
            x = nop(); x.cfg_we = 1; x.cfg_ch = 2'(c); x.cfg_pat = 8'hFF;
            apply(x, $sformatf("cfg_ff[%0d]", c));
        end
        x = nop(); x.bpm_we = 1; x.bpm = 10; apply(x, "bpm10");
        for (int k = 0; k <= 80; k++) begin
            x = nop(); x.start = (k == 0); x.play = 1;
            x.tick = (k % 10 == 0);
            x.idx  = 3'((k / 10) % 8);
            x.trig = x.tick ? 4'hF : 4'h0;
            apply(x, $sformatf("bpm10[%0d]", k));
        end

        // fractional tempo: bpm 30 carries the remainder, giving a 4,3,3 rhythm
        x = nop(); x.stop = 1; apply(x, "stop");
        x = nop(); x.bpm_we = 1; x.bpm = 30; apply(x, "bpm30");
        tk_at = '{0, 4, 7, 10, 14, 17, 20, 24, 27, 30, 34};
        nt = 0;
        for (int k = 0; k <= 34; k++) begin
            x = nop(); x.start = (k == 0); x.play = 1;
            x.tick = (nt < 11) && (k == tk_at[nt]);
            if (x.tick) nt++;
            x.idx  = 3'((nt - 1) % 8);
            x.trig = x.tick ? 4'hF : 4'h0;
            apply(x, $sformatf("bpm30[%0d]", k));
        end

        // reset mid-play wins over a simultaneous start, then defaults: bpm 120 ticks every cycle, empty patterns
        x = nop(); x.rst = 1; x.start = 1; apply(x, "reset_mid_play");
        for (int k = 0; k < 5; k++) begin
            x = nop(); x.start = (k == 0); x.play = 1; x.tick = 1; x.idx = 3'(k);
            apply(x, $sformatf("post_reset[%0d]", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
